// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, limits and state encoding for the D/I memory port arbiter.
// Imported by the arbiter top and its starvation-counter sub-module.
package mem_port_arbiter_pkg;

    localparam int DEF_ISIZE        = 16;
    localparam int DEF_DSIZE        = 32;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int CNT_W            = 4;

    typedef enum logic {
        NORMAL  = 1'b0,
        FAVOR_I = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive cycles in which port I asked and lost.
// Once the count reaches the limit, port I is favoured for one grant.
module mem_arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ifetch_req,
    input  logic i_ifetch_gnt,
    output logic o_favor
);

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_lost;

    assign w_lost = i_ifetch_req & ~i_ifetch_gnt;

    // NOTE: reset is synchronous here, so it lives inside the clocked branch and
    // state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_state <= NORMAL;
        end else begin
            if (!w_lost)
                r_cnt <= '0;
            else if (r_cnt != LIMIT)
                r_cnt <= r_cnt + 4'd1;

            case (r_state)
                NORMAL:  if (w_lost && r_cnt == LIMIT_M1) r_state <= FAVOR_I;
                FAVOR_I: if (i_ifetch_gnt || !i_ifetch_req) r_state <= NORMAL;
                default: r_state <= NORMAL;
            endcase
        end
    end

    assign o_favor = (r_state == FAVOR_I);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, synchronous-read memory between a data port (D, read/write)
// and an instruction-fetch port (I, read-only); read data returns one cycle later.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ISIZE        = DEF_ISIZE,
    parameter int DSIZE        = DEF_DSIZE,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [ISIZE-1:0] d_addr,
    input  logic [DSIZE-1:0] d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [DSIZE-1:0] d_rdata,
    input  logic             i_req,
    input  logic [ISIZE-1:0] i_addr,
    output logic             i_gnt,
    output logic             i_rvalid,
    output logic [DSIZE-1:0] i_rdata,
    output logic             mem_wen,
    output logic [ISIZE-1:0] mem_addr,
    output logic [DSIZE-1:0] mem_wdata,
    input  logic [DSIZE-1:0] mem_rdata
);

    logic             w_favor;
    logic             w_d_gnt;
    logic             w_i_gnt;
    logic [ISIZE-1:0] w_mem_addr;
    logic [ISIZE-1:0] r_last_addr;
    logic             r_d_rvalid;
    logic             r_i_rvalid;

    mem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk          (clk),
        .rst          (rst),
        .i_ifetch_req (i_req),
        .i_ifetch_gnt (w_i_gnt),
        .o_favor      (w_favor)
    );

    // NOTE: every combinational output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_d_gnt = 1'b0;
        w_i_gnt = 1'b0;
        if (!rst) begin
            if (w_favor) begin
                if (i_req)      w_i_gnt = 1'b1;
                else if (d_req) w_d_gnt = 1'b1;
            end else begin
                if (d_req)      w_d_gnt = 1'b1;
                else if (i_req) w_i_gnt = 1'b1;
            end
        end
    end

    // Idle cycles replay the last address so the memory's read register stays put;
    // reset forces zero so it clears while the image loads.
    always_comb begin
        w_mem_addr = r_last_addr;
        if (rst)          w_mem_addr = '0;
        else if (w_d_gnt) w_mem_addr = d_addr;
        else if (w_i_gnt) w_mem_addr = i_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_addr <= '0;
            r_d_rvalid  <= 1'b0;
            r_i_rvalid  <= 1'b0;
        end else begin
            r_last_addr <= w_mem_addr;
            r_d_rvalid  <= w_d_gnt & ~d_we;
            r_i_rvalid  <= w_i_gnt;
        end
    end

    assign d_gnt     = w_d_gnt;
    assign i_gnt     = w_i_gnt;
    assign mem_wen   = w_d_gnt & d_we;
    assign mem_addr  = w_mem_addr;
    assign mem_wdata = d_wdata;
    assign d_rvalid  = r_d_rvalid;
    assign i_rvalid  = r_i_rvalid;
    assign d_rdata   = mem_rdata;
    assign i_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised + directed bench for mem_port_arbiter with a behavioural memory,
// an arbitration reference model and a read-response scoreboard.
module tb_mem_port_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk;
    logic          rst;
    logic          d_req, d_we, i_req;
    logic [AW-1:0] d_addr, i_addr, mem_addr;
    logic [DW-1:0] d_wdata, d_rdata, i_rdata, mem_wdata, mem_rdata;
    logic          d_gnt, d_rvalid, i_gnt, i_rvalid, mem_wen;

    mem_port_arbiter #(
        .ISIZE        (AW),
        .DSIZE        (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory environment: write and read-address register update on the same edge.
    logic [DW-1:0] mem [0:65535];
    logic [AW-1:0] r_mem_addr;

    function automatic logic [DW-1:0] img(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_1234;
    endfunction

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = img(16'(a));
    end

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        r_mem_addr <= mem_addr;
    end
    assign mem_rdata = mem[r_mem_addr];

    // Checking infrastructure
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: contents written so far, I's consecutive-loss run, last address.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          dq[$];
    exp_t          iq[$];
    logic [DW-1:0] model_mem [logic [AW-1:0]];
    int            lost_run  = 0;
    logic [AW-1:0] last_addr = '0;
    int            n_edges   = 0;
    logic          mdl_d_gnt, mdl_i_gnt;

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return img(a);
    endfunction

    task automatic cycle(input logic r, input logic dr, input logic dwe,
                         input logic [AW-1:0] da, input logic [DW-1:0] dw,
                         input logic ir, input logic [AW-1:0] ia);
        logic          eg_d, eg_i, favored, e_wen;
        logic [AW-1:0] e_addr;
        exp_t          e;
        @(negedge clk);
        rst = r; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dw;
        i_req = ir; i_addr = ia;
        #1;
        favored = (lost_run >= LIMIT);
        eg_d = 1'b0;
        eg_i = 1'b0;
        if (!r) begin
            if (favored) begin
                eg_i = ir;
                eg_d = dr && !ir;
            end else begin
                eg_d = dr;
                eg_i = ir && !dr;
            end
        end
        e_wen  = eg_d && dwe;
        e_addr = r ? '0 : eg_d ? da : eg_i ? ia : last_addr;
        check("grants_d_i_wen", {61'b0, d_gnt, i_gnt, mem_wen}, {61'b0, eg_d, eg_i, e_wen});
        check("mem_addr", 64'(mem_addr), 64'(e_addr));
        if (e_wen) check("mem_wdata", 64'(mem_wdata), 64'(dw));

        if (r)               lost_run = 0;
        else if (ir && !eg_i) lost_run++;
        else                 lost_run = 0;
        last_addr = e_addr;
        if (eg_d && !dwe) begin
            e.due = n_edges + 1; e.data = exp_read(da); dq.push_back(e);
        end
        if (eg_i) begin
            e.due = n_edges + 1; e.data = exp_read(ia); iq.push_back(e);
        end
        if (e_wen) model_mem[da] = dw;
        mdl_d_gnt = eg_d;
        mdl_i_gnt = eg_i;
    endtask

    // Monitor: every cycle compare rvalid/rdata against the scoreboard queues.
    initial begin
        exp_t e;
        logic exp_v;
        forever begin
            @(posedge clk);
            n_edges++;
            #2;
            exp_v = (dq.size() > 0) && (dq[0].due == n_edges);
            check("d_rvalid", 64'(d_rvalid), 64'(exp_v));
            if (exp_v) begin
                e = dq.pop_front();
                if (d_rvalid === 1'b1) check("d_rdata", 64'(d_rdata), 64'(e.data));
            end
            exp_v = (iq.size() > 0) && (iq[0].due == n_edges);
            check("i_rvalid", 64'(i_rvalid), 64'(exp_v));
            if (exp_v) begin
                e = iq.pop_front();
                if (i_rvalid === 1'b1) check("i_rdata", 64'(i_rdata), 64'(e.data));
            end
        end
    end

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 15));
    endfunction

    logic          d_pend, pd_we, i_pend, rr;
    logic [AW-1:0] pd_addr, pi_addr;
    logic [DW-1:0] pd_wdata;

    initial begin
        rst = 1'b1; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        i_req = 1'b0; i_addr = '0;

        // Reset then idle
        repeat (2) cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);

        // I-only read
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 16'h0010);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);

        // Write then read-after-write to the same address
        cycle(1'b0, 1'b1, 1'b1, 16'h0040, 32'hDEAD_BEEF, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0040, '0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);

        // Continuous contention: D x4, I x1, repeating
        repeat (12) cycle(1'b0, 1'b1, 1'b0, 16'h0001, '0, 1'b1, 16'h0002);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);

        // Starvation release: I drops once the count reaches 3, so it must lose 4 more
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 16'h0003, '0, 1'b1, 16'h0004);
        cycle(1'b0, 1'b1, 1'b0, 16'h0003, '0, 1'b0, '0);
        repeat (6) cycle(1'b0, 1'b1, 1'b0, 16'h0003, '0, 1'b1, 16'h0004);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);

        // Reset mid-read, with a D write held during reset that must not reach memory
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 16'h0010);
        cycle(1'b1, 1'b1, 1'b1, 16'h0077, 32'h1234_5678, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0077, '0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);

        // Randomised traffic; requesters hold their request until granted
        d_pend = 1'b0; i_pend = 1'b0;
        pd_we = 1'b0; pd_addr = '0; pd_wdata = '0; pi_addr = '0;
        for (int c = 0; c < 800; c++) begin
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend   = 1'b1;
                pd_we    = 1'($urandom_range(0, 1));
                pd_addr  = rand_addr();
                pd_wdata = $urandom;
            end
            if (!i_pend && $urandom_range(0, 3) != 0) begin
                i_pend  = 1'b1;
                pi_addr = rand_addr();
            end
            rr = ($urandom_range(0, 149) == 0);
            cycle(rr, d_pend, pd_we, pd_addr, pd_wdata, i_pend, pi_addr);
            if (mdl_d_gnt) d_pend = 1'b0;
            if (mdl_i_gnt) i_pend = 1'b0;
        end

        repeat (3) cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        check("d_queue_drained", 64'(dq.size()), 64'd0);
        check("i_queue_drained", 64'(iq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
